// File: rtl/nios_system_vga_cpu_mul_combine.sv
// Multiplier combine stage: merges three 16x16 partial products into the low 32 bits
// of a 32x32 product through a two-stage valid/ready pipeline carrying a destination tag.
module nios_system_vga_cpu_mul_combine #(
   parameter int unsigned TAG_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      M_mul_cell_p1,
   input  logic [31:0]      M_mul_cell_p2,
   input  logic [31:0]      M_mul_cell_p3,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      W_mul_result,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy
);

   logic             s1_valid;
   logic [31:0]      s1_p1;
   logic [15:0]      s1_mid;
   logic [TAG_W-1:0] s1_tag;
   logic             s2_valid;

   logic             s1_load;
   logic             s2_adv;
   logic [15:0]      mid_sum;
   logic [31:0]      s2_sum;

   // Only the low halves of p2/p3 land inside the low 32 bits once shifted by 16.
   always_comb begin
      mid_sum  = M_mul_cell_p2[15:0] + M_mul_cell_p3[15:0];
      s2_sum   = s1_p1 + {s1_mid, 16'h0000};
      s2_adv   = s1_valid && (!s2_valid || out_ready);
      in_ready = !s1_valid || s2_adv;
      s1_load  = in_valid && in_ready;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid     <= 1'b0;
         s2_valid     <= 1'b0;
         s1_p1        <= '0;
         s1_mid       <= '0;
         s1_tag       <= '0;
         W_mul_result <= '0;
         out_tag      <= '0;
      end else if (flush) begin
         // Kill both stages; data registers keep their contents.
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
      end else begin
         s1_valid <= s1_load || (s1_valid && !s2_adv);
         s2_valid <= s2_adv || (s2_valid && !out_ready);
         if (s1_load) begin
            s1_p1  <= M_mul_cell_p1;
            s1_mid <= mid_sum;
            s1_tag <= in_tag;
         end
         if (s2_adv) begin
            W_mul_result <= s2_sum;
            out_tag      <= s1_tag;
         end
      end
   end

   assign out_valid = s2_valid;
   assign busy      = s1_valid || s2_valid;

endmodule

// File: tb/tb_nios_system_vga_cpu_mul_combine.sv
// Directed self-checking bench for the multiplier combine stage.
module tb_nios_system_vga_cpu_mul_combine;

   localparam int unsigned TAG_W = 5;

   logic             clk = 1'b0;
   logic             reset;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      p1, p2, p3;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      W_mul_result;
   logic [TAG_W-1:0] out_tag;
   logic             busy;

   int errors = 0;
   int checks = 0;

   nios_system_vga_cpu_mul_combine #(.TAG_W(TAG_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .M_mul_cell_p1(p1),
      .M_mul_cell_p2(p2),
      .M_mul_cell_p3(p3),
      .in_tag       (in_tag),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .W_mul_result (W_mul_result),
      .out_tag      (out_tag),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [TAG_W-1:0] t);
      in_valid = v; p1 = a; p2 = b; p3 = c; in_tag = t;
   endtask

   task automatic test_reset();
      reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
      drive(1'b0, '0, '0, '0, '0);
      tick(); tick();
      reset = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++;
      if (W_mul_result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=00000000", W_mul_result); end
      checks++;
      if (out_tag !== 5'd0) begin errors++; $display("FAIL reset_tag got=%0d exp=0", out_tag); end
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_basic();
      out_ready = 1'b1;
      drive(1'b1, 32'h8, 32'h6, 32'h4, 5'd3);
      tick();
      drive(1'b0, '0, '0, '0, '0);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got=%b exp=0", out_valid); end
      tick();
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
      checks++;
      if (W_mul_result !== 32'h000A0008) begin errors++; $display("FAIL basic_result got=%h exp=000a0008", W_mul_result); end
      checks++;
      if (out_tag !== 5'd3) begin errors++; $display("FAIL basic_tag got=%0d exp=3", out_tag); end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got=%b exp=0", out_valid); end
   endtask

   task automatic test_wrap();
      logic [31:0] vp1 [3];
      logic [31:0] vp2 [3];
      logic [31:0] vp3 [3];
      logic [31:0] vexp[3];
      vp1[0] = 32'hFFFF0000; vp2[0] = 32'h00000001; vp3[0] = 32'h00000000; vexp[0] = 32'h00000000;
      vp1[1] = 32'hFFFFFFFF; vp2[1] = 32'h00008000; vp3[1] = 32'h00008000; vexp[1] = 32'hFFFFFFFF;
      vp1[2] = 32'h00000000; vp2[2] = 32'hABCD0001; vp3[2] = 32'h12340002; vexp[2] = 32'h00030000;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, vp1[i], vp2[i], vp3[i], 5'(i + 10));
         tick();
         drive(1'b0, '0, '0, '0, '0);
         tick();
         checks++;
         if (out_valid !== 1'b1 || W_mul_result !== vexp[i])
            begin errors++; $display("FAIL wrap_%0d got=%h valid=%b exp=%h", i, W_mul_result, out_valid, vexp[i]); end
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [31:0] e;
      out_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         if (i < 4) drive(1'b1, 32'(i) << 8, 32'(i), 32'h1, 5'(i + 1));
         else       drive(1'b0, '0, '0, '0, '0);
         if (i < 4) begin
            #1;
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready_%0d got=%b exp=1", i, in_ready); end
         end
         tick();
         if (i >= 1 && i <= 4) begin
            e = ((32'(i - 1) + 32'd1) << 16) + (32'(i - 1) << 8);
            checks++;
            if (out_valid !== 1'b1 || W_mul_result !== e || out_tag !== 5'(i))
               begin errors++; $display("FAIL b2b_out_%0d got=%h tag=%0d valid=%b exp=%h tag=%0d", i, W_mul_result, out_tag, out_valid, e, i); end
         end
      end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
   endtask

   task automatic test_backpressure();
      // A: p1=1,p2=1,p3=1 -> 0x00020001; B: p1=2,p2=2 -> 0x00020002; C: p1=3,p3=3 -> 0x00030003
      logic exp_rdy [5];
      exp_rdy[0] = 1'b1; exp_rdy[1] = 1'b1; exp_rdy[2] = 1'b0; exp_rdy[3] = 1'b0; exp_rdy[4] = 1'b0;
      out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         if (c == 0)      drive(1'b1, 32'h1, 32'h1, 32'h1, 5'd21);
         else if (c == 1) drive(1'b1, 32'h2, 32'h2, 32'h0, 5'd22);
         else             drive(1'b1, 32'h3, 32'h0, 32'h3, 5'd23);
         #1;
         checks++;
         if (in_ready !== exp_rdy[c]) begin errors++; $display("FAIL bp_in_ready_%0d got=%b exp=%b", c, in_ready, exp_rdy[c]); end
         tick();
         if (c >= 1) begin
            checks++;
            if (out_valid !== 1'b1 || W_mul_result !== 32'h00020001 || out_tag !== 5'd21)
               begin errors++; $display("FAIL bp_hold_%0d got=%h tag=%0d valid=%b exp=00020001 tag=21", c, W_mul_result, out_tag, out_valid); end
         end
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); end
      tick();
      drive(1'b0, '0, '0, '0, '0);
      checks++;
      if (out_valid !== 1'b1 || W_mul_result !== 32'h00020002 || out_tag !== 5'd22)
         begin errors++; $display("FAIL bp_second got=%h tag=%0d valid=%b exp=00020002 tag=22", W_mul_result, out_tag, out_valid); end
      tick();
      checks++;
      if (out_valid !== 1'b1 || W_mul_result !== 32'h00030003 || out_tag !== 5'd23)
         begin errors++; $display("FAIL bp_third got=%h tag=%0d valid=%b exp=00030003 tag=23", W_mul_result, out_tag, out_valid); end
      tick();
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_drain valid=%b busy=%b exp=0/0", out_valid, busy); end
   endtask

   task automatic fill_both();
      out_ready = 1'b0;
      drive(1'b1, 32'h11, 32'h0, 32'h0, 5'd7);
      tick();
      drive(1'b1, 32'h22, 32'h0, 32'h0, 5'd8);
      tick();
   endtask

   task automatic test_flush();
      fill_both();
      checks++;
      if (out_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL flush_prefill valid=%b busy=%b exp=1/1", out_valid, busy); end
      flush = 1'b1; out_ready = 1'b1;
      drive(1'b1, 32'h33, 32'h0, 32'h0, 5'd9);
      tick();
      flush = 1'b0;
      drive(1'b0, '0, '0, '0, '0);
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL flush_kill valid=%b busy=%b exp=0/0", out_valid, busy); end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_discard got=%b exp=0", out_valid); end
      drive(1'b1, 32'h5, 32'h2, 32'h1, 5'd17);
      tick();
      drive(1'b0, '0, '0, '0, '0);
      tick();
      checks++;
      if (out_valid !== 1'b1 || W_mul_result !== 32'h00030005 || out_tag !== 5'd17)
         begin errors++; $display("FAIL flush_after got=%h tag=%0d valid=%b exp=00030005 tag=17", W_mul_result, out_tag, out_valid); end
      tick();
   endtask

   task automatic test_reset_midstream();
      fill_both();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid valid=%b busy=%b exp=0/0", out_valid, busy); end
      checks++;
      if (W_mul_result !== 32'h0 || out_tag !== 5'd0) begin errors++; $display("FAIL rst_mid_data got=%h tag=%0d exp=00000000 tag=0", W_mul_result, out_tag); end
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready got=%b exp=1", in_ready); end
      drive(1'b0, '0, '0, '0, '0);
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_back_to_back();
      test_backpressure();
      test_flush();
      test_reset_midstream();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
